// File: rtl/id_ex_reg_pkg.sv
// rtl/id_ex_reg_pkg.sv - shared ALU op classes, funct codes and ID/EX control bundle
package id_ex_reg_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  // R-type funct codes decoded by the ALU control unit in EX
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic       memToReg;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       bne;
    logic       aluSrc;
    logic       regDst;
    logic [1:0] aluOp;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // All-zero bundle: no write, no memory access, no branch, aluOp = add
  localparam ctrl_t BUBBLE = '0;

  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
    return valid ? c : BUBBLE;
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// rtl/id_ex_reg_if.sv - ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);

  logic                  id_valid;
  logic                  id_regWrite;
  logic                  id_memToReg;
  logic                  id_memRead;
  logic                  id_memWrite;
  logic                  id_branch;
  logic                  id_bne;
  logic                  id_aluSrc;
  logic                  id_regDst;
  logic [1:0]            id_aluOp;
  logic [5:0]            id_funct;
  logic [DATA_W-1:0]     id_pcPlus4;
  logic [DATA_W-1:0]     id_rdata1;
  logic [DATA_W-1:0]     id_rdata2;
  logic [DATA_W-1:0]     id_imm;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;

  logic                  ex_valid;
  logic                  ex_regWrite;
  logic                  ex_memToReg;
  logic                  ex_memRead;
  logic                  ex_memWrite;
  logic                  ex_branch;
  logic                  ex_bne;
  logic                  ex_aluSrc;
  logic                  ex_regDst;
  logic [1:0]            ex_aluOp;
  logic [5:0]            ex_funct;
  logic [DATA_W-1:0]     ex_pcPlus4;
  logic [DATA_W-1:0]     ex_rdata1;
  logic [DATA_W-1:0]     ex_rdata2;
  logic [DATA_W-1:0]     ex_imm;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic [REG_ADDR_W-1:0] ex_rd;

  modport master (
    output id_valid, id_regWrite, id_memToReg, id_memRead, id_memWrite,
           id_branch, id_bne, id_aluSrc, id_regDst, id_aluOp, id_funct,
           id_pcPlus4, id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd,
    input  ex_valid, ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite,
           ex_branch, ex_bne, ex_aluSrc, ex_regDst, ex_aluOp, ex_funct,
           ex_pcPlus4, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_rd
  );

  modport slave (
    input  id_valid, id_regWrite, id_memToReg, id_memRead, id_memWrite,
           id_branch, id_bne, id_aluSrc, id_regDst, id_aluOp, id_funct,
           id_pcPlus4, id_rdata1, id_rdata2, id_imm, id_rs, id_rt, id_rd,
    output ex_valid, ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite,
           ex_branch, ex_bne, ex_aluSrc, ex_regDst, ex_aluOp, ex_funct,
           ex_pcPlus4, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_rd
  );

endinterface

// File: rtl/id_ex_reg_pipe_ctrl_bundle.sv
// rtl/id_ex_reg_pipe_ctrl_bundle.sv - generic pipeline register slice with flush > stall > load
module pipe_ctrl_bundle #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (flush) begin
      data_d = '0;
    end else if (!stall) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with stall, flush, valid gating and bubble counter
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  id_ex_reg_if.slave       bus,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int DBUS_W = 6 + 4 * DATA_W + 3 * REG_ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t             ctrl_raw;
  ctrl_t             ctrl_in;
  ctrl_t             ctrl_out;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DBUS_W-1:0] data_in;
  logic [DBUS_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  always_comb begin
    ctrl_raw          = BUBBLE;
    ctrl_raw.valid    = bus.id_valid;
    ctrl_raw.regWrite = bus.id_regWrite;
    ctrl_raw.memToReg = bus.id_memToReg;
    ctrl_raw.memRead  = bus.id_memRead;
    ctrl_raw.memWrite = bus.id_memWrite;
    ctrl_raw.branch   = bus.id_branch;
    ctrl_raw.bne      = bus.id_bne;
    ctrl_raw.aluSrc   = bus.id_aluSrc;
    ctrl_raw.regDst   = bus.id_regDst;
    ctrl_raw.aluOp    = bus.id_aluOp;
  end

  // An invalid ID slot enters EX as an inert bundle, but is not counted as a bubble
  assign ctrl_in = gate_ctrl(ctrl_raw, bus.id_valid);

  assign data_in = {bus.id_funct, bus.id_pcPlus4, bus.id_rdata1, bus.id_rdata2,
                    bus.id_imm, bus.id_rs, bus.id_rt, bus.id_rd};

  pipe_ctrl_bundle #(.W(CTRL_W)) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .d_i   (ctrl_in),
    .q_o   (ctrl_q)
  );

  pipe_ctrl_bundle #(.W(DBUS_W)) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .d_i   (data_in),
    .q_o   (data_q)
  );

  assign ctrl_out        = ctrl_t'(ctrl_q);
  assign bus.ex_valid    = ctrl_out.valid;
  assign bus.ex_regWrite = ctrl_out.regWrite;
  assign bus.ex_memToReg = ctrl_out.memToReg;
  assign bus.ex_memRead  = ctrl_out.memRead;
  assign bus.ex_memWrite = ctrl_out.memWrite;
  assign bus.ex_branch   = ctrl_out.branch;
  assign bus.ex_bne      = ctrl_out.bne;
  assign bus.ex_aluSrc   = ctrl_out.aluSrc;
  assign bus.ex_regDst   = ctrl_out.regDst;
  assign bus.ex_aluOp    = ctrl_out.aluOp;

  assign {bus.ex_funct, bus.ex_pcPlus4, bus.ex_rdata1, bus.ex_rdata2,
          bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_rd} = data_q;

  // Flush counts even when stall is also high; the counter sticks at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (flush && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;

endmodule
